// File: rtl/iddr_deser.sv
`default_nettype none
//==============================================================================
// Module   : iddr_deser
// Purpose  : Multi-lane DDR input deserialiser. Each lane samples d on both
//            clock edges, builds a 2*RATIO-bit history and emits a RATIO-bit
//            word every RATIO/2 cycles on a shared word boundary. A per-lane
//            bit offset, advanced by bitslip requests, moves that lane's word
//            boundary one bit at a time. An optional training-pattern checker
//            reports per-lane lock.
// Ports    : clk       - sole clock, data sampled on both edges
//            rst_n     - asynchronous active-low reset
//            d         - DDR serial data, one bit per lane
//            bitslip   - per-lane request to delay the word boundary one bit
//            out_data  - lane n in [n*RATIO +: RATIO], earliest bit in MSB
//            out_valid - one-cycle strobe, out_data valid for all lanes
//            lock      - per-lane training-pattern lock flag
// Options  : IDDR_DESER_PATTERN_CHECK_EN - enables training-pattern lock
//            detection; when undefined, lock is tied low.
// Revision : 1.0 - initial release
//==============================================================================
module iddr_deser #(
    parameter int               WIDTH         = 1,
    parameter int               RATIO         = 8,
    parameter logic [RATIO-1:0] TRAIN_PATTERN = 8'hA5,
    parameter int               LOCK_COUNT    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       d,
    input  logic [WIDTH-1:0]       bitslip,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       lock
);

    localparam int c_cnt_w  = (RATIO > 2) ? $clog2(RATIO / 2) : 1;
    localparam int c_off_w  = $clog2(RATIO);
    localparam int c_hist_w = 2 * RATIO;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RATIO / 2 - 1);
    localparam logic [c_off_w-1:0] c_off_last = c_off_w'(RATIO - 1);

    // Shared word counter; the last count is the boundary cycle on which
    // every lane loads its output word.
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_valid;
    logic               w_boundary;

    assign w_boundary = (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= w_boundary ? '0 : r_cnt + c_cnt_w'(1);
            r_valid <= w_boundary;
        end
    end

    assign out_valid = r_valid;

    for (genvar n = 0; n < WIDTH; n++) begin : g_lane
        logic                r_a_cap;
        logic                r_b_cap;
        logic                r_a;
        logic                r_b;
        logic [c_hist_w-1:0] r_hist;
        logic [c_off_w-1:0]  r_off;
        logic                r_pend;
        logic [RATIO-1:0]    r_data;
        logic [RATIO-1:0]    w_word;

        // Larger offsets reach further back into the history (older bits).
        assign w_word = r_hist[r_off +: RATIO];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a_cap <= 1'b0;
            end else begin
                r_a_cap <= d[n];
            end
        end

        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_b_cap <= 1'b0;
            end else begin
                r_b_cap <= d[n];
            end
        end

        // Both samples move into the rising-edge domain together; the
        // rising-edge sample is the earlier bit, so it lands one place
        // higher (older) in the history.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a    <= 1'b0;
                r_b    <= 1'b0;
                r_hist <= '0;
                r_off  <= '0;
                r_pend <= 1'b0;
                r_data <= '0;
            end else begin
                r_a    <= r_a_cap;
                r_b    <= r_b_cap;
                r_hist <= {r_hist[c_hist_w-3:0], r_a, r_b};
                // A new request always re-arms pending, even on the
                // boundary that consumes the previous one.
                r_pend <= bitslip[n] | (r_pend & ~w_boundary);
                if (w_boundary) begin
                    r_data <= w_word;
                    if (r_pend) begin
                        r_off <= (r_off == c_off_last) ? '0 : r_off + c_off_w'(1);
                    end
                end
            end
        end

        assign out_data[n*RATIO +: RATIO] = r_data;

`ifdef IDDR_DESER_PATTERN_CHECK_EN
        logic [3:0] r_lcnt;
        logic       r_lock;
        logic [3:0] w_lcnt_inc;

        assign w_lcnt_inc = (r_lcnt == 4'd15) ? r_lcnt : r_lcnt + 4'd1;

        // An applied bitslip invalidates the match history just like a
        // mismatching word does.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lcnt <= 4'd0;
                r_lock <= 1'b0;
            end else if (w_boundary) begin
                if (r_pend || (w_word != TRAIN_PATTERN)) begin
                    r_lcnt <= 4'd0;
                    r_lock <= 1'b0;
                end else begin
                    r_lcnt <= w_lcnt_inc;
                    r_lock <= (w_lcnt_inc >= 4'(LOCK_COUNT));
                end
            end
        end

        assign lock[n] = r_lock;
`else
        // The training parameters have no function in this build; they are
        // folded into a constant-zero term so the parameter list stays the
        // same for both builds.
        assign lock[n] = 1'b0 & (|TRAIN_PATTERN) & (LOCK_COUNT > 0);
`endif
    end

endmodule
`default_nettype wire
